port_out_rr: RTL and testbench

//  Output-port arbiter/multiplexer for the NUM_IN-input bit-serial router. Frame-locked, round-robin.

---
 rtl/port_out_rr_if.sv | 28 ++
 rtl/port_out_rr.sv | 171 +++++++++++++++++
 tb/tb_port_out_rr.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/port_out_rr_if.sv
// Bus bundle for one router output port: per-input serial lanes and requests in,
// forwarded serial stream plus grant/back-pressure/status out.
interface port_out_rr_if #(
    parameter int NUM_IN = 16,
    parameter int CNT_W  = 16
) ();
    logic [NUM_IN-1:0] din;
    logic [NUM_IN-1:0] frame_n;
    logic [NUM_IN-1:0] valid_n;
    logic [NUM_IN-1:0] req;
    logic              dout;
    logic              frame_n_o;
    logic              valid_n_o;
    logic [NUM_IN-1:0] grant;
    logic [NUM_IN-1:0] busy_n;
    logic              abort;
    logic [CNT_W-1:0]  pkt_count;

    modport master (
        output din, frame_n, valid_n, req,
        input  dout, frame_n_o, valid_n_o, grant, busy_n, abort, pkt_count
    );

    modport slave (
        input  din, frame_n, valid_n, req,
        output dout, frame_n_o, valid_n_o, grant, busy_n, abort, pkt_count
    );
endinterface

// File: rtl/port_out_rr.sv
// Frame-locked round-robin output-port arbiter/mux for the bit-serial router,
// with stall timeout, protocol-error abort, per-input back-pressure and packet count.
module port_out_rr #(
    parameter int NUM_IN  = 16,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    port_out_rr_if.slave  bus
);
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int STL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [STL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [NUM_IN-1:0] grant_q, grant_d;
    logic [NUM_IN-1:0] busy_n_q, busy_n_d;
    logic              dout_q, dout_d;
    logic              frame_q, frame_d;
    logic              valid_q, valid_d;
    logic              abort_q, abort_d;
    logic [CNT_W-1:0]  pkt_q, pkt_d;

    logic [NUM_IN-1:0] cand_s;
    logic              win_found_s;
    logic [IDX_W-1:0]  win_s;
    logic              own_f_s, own_v_s, own_d_s;

    assign cand_s  = bus.req & ~bus.frame_n;
    assign own_f_s = bus.frame_n[owner_q];
    assign own_v_s = bus.valid_n[owner_q];
    assign own_d_s = bus.din[owner_q];

    // Round-robin winner: first candidate at or after rr_ptr, wrapping upward.
    always_comb begin
        int idx;
        idx         = 0;
        win_found_s = 1'b0;
        win_s       = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end else begin
                idx = idx;
            end
            if (!win_found_s && cand_s[idx]) begin
                win_found_s = 1'b1;
                win_s       = IDX_W'(idx);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and registered-output logic; outputs default to the idle 1/1/0 pattern.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = stall_cnt_q;
        grant_d     = grant_q;
        busy_n_d    = busy_n_q;
        dout_d      = 1'b0;
        frame_d     = 1'b1;
        valid_d     = 1'b1;
        abort_d     = 1'b0;
        pkt_d       = pkt_q;
        case (state_q)
            IDLE: begin
                if (win_found_s) begin
                    owner_d  = win_s;
                    grant_d  = {{(NUM_IN-1){1'b0}}, 1'b1} << win_s;
                    busy_n_d = ~({{(NUM_IN-1){1'b0}}, 1'b1} << win_s);
                    rr_ptr_d = (win_s == IDX_W'(NUM_IN - 1)) ? '0 : win_s + IDX_W'(1);
                    frame_d  = bus.frame_n[win_s];
                    valid_d  = bus.valid_n[win_s];
                    dout_d   = bus.din[win_s];
                    state_d  = LOCK;
                end else begin
                    state_d  = IDLE;
                end
            end
            LOCK: begin
                if (!own_f_s && !own_v_s) begin
                    frame_d     = 1'b0;
                    valid_d     = 1'b0;
                    dout_d      = own_d_s;
                    stall_cnt_d = '0;
                end else if (own_f_s && !own_v_s) begin
                    frame_d     = 1'b1;
                    valid_d     = 1'b0;
                    dout_d      = own_d_s;
                    stall_cnt_d = '0;
                    pkt_d       = pkt_q + CNT_W'(1);
                    state_d     = GAP;
                end else if (own_f_s && own_v_s) begin
                    abort_d     = 1'b1;
                    state_d     = GAP;
                end else if (stall_cnt_q == STL_W'(TIMEOUT - 1)) begin
                    // This edge is the TIMEOUT-th consecutive stalled cycle.
                    abort_d     = 1'b1;
                    state_d     = GAP;
                end else begin
                    frame_d     = 1'b0;
                    valid_d     = 1'b1;
                    dout_d      = own_d_s;
                    stall_cnt_d = stall_cnt_q + STL_W'(1);
                end
            end
            GAP: begin
                grant_d     = '0;
                busy_n_d    = '1;
                stall_cnt_d = '0;
                state_d     = IDLE;
            end
            default: begin
                grant_d     = '0;
                busy_n_d    = '1;
                stall_cnt_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
            grant_q     <= '0;
            busy_n_q    <= '1;
            dout_q      <= 1'b0;
            frame_q     <= 1'b1;
            valid_q     <= 1'b1;
            abort_q     <= 1'b0;
            pkt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
            grant_q     <= grant_d;
            busy_n_q    <= busy_n_d;
            dout_q      <= dout_d;
            frame_q     <= frame_d;
            valid_q     <= valid_d;
            abort_q     <= abort_d;
            pkt_q       <= pkt_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.frame_n_o = frame_q;
    assign bus.valid_n_o = valid_q;
    assign bus.grant     = grant_q;
    assign bus.busy_n    = busy_n_q;
    assign bus.abort     = abort_q;
    assign bus.pkt_count = pkt_q;
endmodule

// File: tb/tb_port_out_rr.sv
// Randomized plus directed bench for port_out_rr against a frame-level reference model.
module tb_port_out_rr;
    localparam int N  = 16;
    localparam int TO = 64;

    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    port_out_rr_if #(.NUM_IN(N), .CNT_W(16)) bus ();

    port_out_rr #(.NUM_IN(N), .TIMEOUT(TO), .CNT_W(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference model: who owns the port, where the pointer sits, expected outputs.
    int          m_owner, m_ptr, m_stall;
    bit          m_gap;
    logic [15:0] m_cnt;
    logic        e_d, e_f, e_v, e_ab;
    logic [N-1:0] e_gr, e_bz;

    // Random source state per input.
    int left_a [N];
    int stl_a  [N];
    bit rq_a   [N];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic idle_out();
        e_f = 1'b1;
        e_v = 1'b1;
        e_d = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] f, input logic [N-1:0] v,
                              input logic [N-1:0] d, input logic [N-1:0] r, input logic rn);
        int w;
        int j;
        e_ab = 1'b0;
        if (!rn) begin
            m_owner = -1; m_ptr = 0; m_stall = 0; m_gap = 0; m_cnt = 16'd0;
            idle_out();
        end else if (m_gap) begin
            m_gap = 0; m_owner = -1; m_stall = 0;
            idle_out();
        end else if (m_owner < 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (w < 0 && r[j] && !f[j]) w = j;
            end
            if (w < 0) idle_out();
            else begin
                m_owner = w; m_ptr = (w + 1) % N;
                e_f = f[w]; e_v = v[w]; e_d = d[w];
            end
        end else begin
            if (!v[m_owner]) begin
                e_f = f[m_owner]; e_v = 1'b0; e_d = d[m_owner];
                m_stall = 0;
                if (f[m_owner]) begin
                    m_cnt = m_cnt + 16'd1;
                    m_gap = 1;
                end
            end else if (f[m_owner]) begin
                idle_out(); e_ab = 1'b1; m_gap = 1;
            end else begin
                m_stall++;
                if (m_stall == TO) begin
                    idle_out(); e_ab = 1'b1; m_gap = 1;
                end else begin
                    e_f = 1'b0; e_v = 1'b1; e_d = d[m_owner];
                end
            end
        end
        e_gr = (m_owner < 0) ? 16'h0000 : (16'h0001 << m_owner);
        e_bz = ~e_gr;
    endtask

    task automatic tick();
        logic [N-1:0] f, v, d, r;
        logic rn;
        f = bus.frame_n; v = bus.valid_n; d = bus.din; r = bus.req; rn = reset_n;
        @(posedge clock);
        model_edge(f, v, d, r, rn);
        #1;
        check_eq("dout",      {31'd0, bus.dout},      {31'd0, e_d});
        check_eq("frame_n_o", {31'd0, bus.frame_n_o}, {31'd0, e_f});
        check_eq("valid_n_o", {31'd0, bus.valid_n_o}, {31'd0, e_v});
        check_eq("abort",     {31'd0, bus.abort},     {31'd0, e_ab});
        check_eq("grant",     {16'd0, bus.grant},     {16'd0, e_gr});
        check_eq("busy_n",    {16'd0, bus.busy_n},    {16'd0, e_bz});
        check_eq("pkt_count", {16'd0, bus.pkt_count}, {16'd0, m_cnt});
    endtask

    task automatic idle_all();
        bus.frame_n = '1;
        bus.valid_n = '1;
        bus.din     = '0;
        bus.req     = '0;
    endtask

    task automatic do_reset();
        idle_all();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            if (left_a[i] == 0 && $urandom_range(0, 7) == 0) begin
                left_a[i] = $urandom_range(2, 9);
                rq_a[i]   = ($urandom_range(0, 1) == 1);
                stl_a[i]  = ($urandom_range(0, 59) == 0) ? 70 : 0;
            end
            bus.din[i] = ($urandom_range(0, 1) == 1);
            if (left_a[i] == 0) begin
                bus.frame_n[i] = 1'b1; bus.valid_n[i] = 1'b1; bus.din[i] = 1'b0;
                bus.req[i] = ($urandom_range(0, 3) == 0);
            end else begin
                bus.req[i] = rq_a[i];
                if (stl_a[i] > 0) begin
                    bus.frame_n[i] = 1'b0; bus.valid_n[i] = 1'b1; stl_a[i]--;
                end else if ($urandom_range(0, 5) == 0) begin
                    bus.frame_n[i] = 1'b0; bus.valid_n[i] = 1'b1;
                end else if ($urandom_range(0, 39) == 0) begin
                    bus.frame_n[i] = 1'b1; bus.valid_n[i] = 1'b1; left_a[i] = 0;
                end else begin
                    bus.frame_n[i] = (left_a[i] == 1); bus.valid_n[i] = 1'b0; left_a[i]--;
                end
            end
        end
    endtask

    initial begin
        logic [7:0]   pat;
        logic [N-1:0] prev_gr;
        logic [N-1:0] order [4];
        int           nserv;
        int           ab_seen;

        m_owner = -1; m_ptr = 0; m_stall = 0; m_gap = 0; m_cnt = 16'd0;
        for (int i = 0; i < N; i++) begin
            left_a[i] = 0; stl_a[i] = 0; rq_a[i] = 0;
        end
        do_reset();

        // Single 0xA5 frame on input 3.
        pat = 8'hA5;
        bus.req[3] = 1'b1;
        for (int b = 7; b >= 0; b--) begin
            bus.frame_n[3] = (b == 0); bus.valid_n[3] = 1'b0; bus.din[3] = pat[b];
            tick();
        end
        idle_all();
        repeat (3) tick();
        check_eq("t1_pkt", {16'd0, bus.pkt_count}, 32'd1);

        // Inputs 0 and 5 requesting back-to-back frames: alternate 0,5,0,5.
        do_reset();
        order[0] = 16'h0001; order[1] = 16'h0020; order[2] = 16'h0001; order[3] = 16'h0020;
        nserv = 0; prev_gr = '0;
        for (int c = 0; c < 40; c++) begin
            bus.req[0] = 1'b1; bus.req[5] = 1'b1;
            bus.frame_n[0] = (c % 4 == 3); bus.frame_n[5] = (c % 4 == 3);
            bus.valid_n[0] = 1'b0; bus.valid_n[5] = 1'b0;
            bus.din[0] = ($urandom_range(0, 1) == 1); bus.din[5] = ($urandom_range(0, 1) == 1);
            tick();
            if (prev_gr == '0 && bus.grant != '0 && nserv < 4) begin
                check_eq("t2_order", {16'd0, bus.grant}, {16'd0, order[nserv]});
                nserv++;
            end
            prev_gr = bus.grant;
        end
        check_eq("t2_served", nserv, 32'd4);

        // Owner 2 stalls for TIMEOUT cycles.
        do_reset();
        idle_all();
        bus.req[2] = 1'b1; bus.frame_n[2] = 1'b0; bus.valid_n[2] = 1'b0;
        repeat (2) tick();
        bus.valid_n[2] = 1'b1;
        ab_seen = 0;
        for (int c = 0; c < TO + 2; c++) begin
            tick();
            if (bus.abort) ab_seen++;
        end
        check_eq("t3_abort_seen", ab_seen, 32'd1);
        check_eq("t3_pkt", {16'd0, bus.pkt_count}, 32'd0);
        idle_all();
        tick();

        // Pointer wrap: serve 14, then 15 beats 0.
        do_reset();
        bus.req[14] = 1'b1; bus.valid_n[14] = 1'b0;
        for (int b = 2; b >= 0; b--) begin
            bus.frame_n[14] = (b == 0);
            tick();
        end
        idle_all();
        repeat (2) tick();
        bus.req[15] = 1'b1; bus.req[0] = 1'b1;
        bus.frame_n[15] = 1'b0; bus.frame_n[0] = 1'b0;
        bus.valid_n[15] = 1'b0; bus.valid_n[0] = 1'b0;
        tick();
        check_eq("t4_wrap", {16'd0, bus.grant}, 32'h8000);
        for (int c = 0; c < 14; c++) begin
            bus.frame_n[15] = (c >= 2);
            bus.valid_n[15] = (c >= 3);
            bus.req[15]     = (c < 3);
            bus.frame_n[0]  = (c % 5 == 4);
            tick();
        end

        // Reset in the middle of a frame on input 1; pointer must restart at 0.
        do_reset();
        bus.req[1] = 1'b1; bus.frame_n[1] = 1'b0; bus.valid_n[1] = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.req[0] = 1'b1; bus.frame_n[0] = 1'b0; bus.valid_n[0] = 1'b0;
        tick();
        check_eq("t5_ptr0", {16'd0, bus.grant}, 32'h0001);

        // Protocol error from owner 7.
        do_reset();
        bus.req[7] = 1'b1; bus.frame_n[7] = 1'b0; bus.valid_n[7] = 1'b0;
        repeat (3) tick();
        bus.frame_n[7] = 1'b1; bus.valid_n[7] = 1'b1;
        tick();
        check_eq("t6_abort", {31'd0, bus.abort}, 32'd1);
        check_eq("t6_pkt", {16'd0, bus.pkt_count}, 32'd0);
        idle_all();
        repeat (2) tick();

        // Randomized traffic from all inputs, with rare resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            reset_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
